uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver that consumes the serial stream produced by UART_Tx and rebuilds the parallel word.
- Oversamples the line at Prescale clocks per bit and majority-votes three mid-bit samples.
- Checks optional even/odd parity and the stop bit.
- Presents each good word with a one-cycle valid strobe. Sits at the link endpoint, feeding the register/FIFO side of the design.

Parameters:
Width, 8, data bits per frame
Prescale, 8, clocks per bit period; must be even and >= 6

Ports:
clk  input  1  system clock, Prescale x bit rate
rst  input  1  synchronous active-low reset
Rx_in  input  1  serial line, idle high
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
P_data  output  Width  last correctly received word
Data_valid  output  1  one-cycle pulse, P_data updated
Par_err  output  1  one-cycle pulse, parity mismatch
Stop_err  output  1  one-cycle pulse, stop bit sampled low
Busy  output  1  high while a frame is being received

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset, while rst==0 at a clk edge:
  - P_data=0; Data_valid=0, Par_err=0, Stop_err=0; Busy=0.
  - FSM=IDLE; counters=0; synchronizer flops=1.
  - Reset mid-frame abandons the frame with no pulses.
- Input path: Rx_in passes through a 2-flop synchronizer (rx_s). All references below use rx_s.
- Counters:
  - os_cnt runs 0..Prescale-1 and wraps; bit_cnt runs 0..Width-1.
  - Sample points within a bit: os_cnt = Prescale/2-1, Prescale/2, Prescale/2+1.
  - bit_val = majority of the three samples, valid at os_cnt==Prescale/2+1 ("sample tick").
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Busy=0. When rx_s==0, go to START, set os_cnt=1, latch PAR_EN/PAR_TYP. Input changes mid-frame are ignored.
  - START, at sample tick:
    - bit_val==1: false start; return to IDLE at the next cycle, no pulses.
    - Otherwise continue; at os_cnt wrap go to DATA with bit_cnt=0.
  - DATA: at each sample tick shift bit_val into shift[bit_cnt] (LSB first). At os_cnt wrap:
    - bit_cnt==Width-1 goes to PARITY if latched PAR_EN else STOP.
    - Otherwise bit_cnt++.
  - PARITY: at sample tick capture p=bit_val. At wrap go to STOP.
  - STOP, at sample tick:
    - Compute exp = ^shift ^ PAR_TYP_latched; par_bad = PAR_EN_latched && (p != exp).
    - Then go to IDLE at the next cycle. The remainder of the stop bit is not waited for, so the next start edge is caught early.
- Outputs, registered and asserted the cycle after the stop-bit sample tick:
  - bit_val==0: Stop_err=1. Par_err=par_bad is still reported. No Data_valid; P_data unchanged.
  - bit_val==1 and par_bad: Par_err=1. No Data_valid; P_data unchanged.
  - bit_val==1 and !par_bad: P_data<=shift, Data_valid=1.
  - All pulses are exactly one cycle. P_data holds until the next good frame.
- Busy: 1 in every state except IDLE, and drops the cycle the output pulse is asserted.
- Latency: Data_valid is asserted (1+Width+PAR_EN)*Prescale + Prescale/2 + 2 clocks after rx_s first reads 0, ±1 clock.
- Back-to-back: a start bit immediately following the stop bit (no idle gap) must be received correctly.
- Parity convention matches UART_Tx: 8'h81 gives even-parity bit 0 and odd-parity bit 1.

Test Plan:
- TX→RX loopback, Prescale=8: drive Rx_in from UART_Tx (its clock = clk/8), PAR_EN=0, data 8'h81 → one Data_valid pulse, P_data=8'h81, no error pulses.
- Loopback with parity, 8'h7f with PAR_TYP=0 (bit 1) and PAR_TYP=1 (bit 0), then 8'h86 with both types → P_data correct, Data_valid each frame, Par_err never.
- Bit-banged frame 8'h81 with PAR_EN=1, PAR_TYP=0 but parity bit 1 → Par_err one cycle, Data_valid=0, P_data keeps its previous value.
- Frame 8'h55 with stop bit 0 → Stop_err one cycle, no Data_valid. A following good frame 8'hA5 → Data_valid, P_data=8'hA5.
- Glitch: Rx_in low for 2 clocks then high → Busy returns low after the START sample tick, no pulses. A 1-clock glitch inside a data bit at os_cnt=Prescale/2 is voted out, word still correct.
- Back-to-back frames 8'h86 then 8'h81 with no idle gap → two Data_valid pulses in order. rst=0 asserted mid-DATA → Busy=0 and no pulse; the next frame 8'h7f is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, Prescale-times oversampling with a
// three-sample majority vote, optional even/odd parity and stop-bit checking.
module uart_rx #(
   parameter int Width    = 8,
   parameter int Prescale = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Rx_in,
   input  logic             PAR_EN,
   input  logic             PAR_TYP,
   output logic [Width-1:0] P_data,
   output logic             Data_valid,
   output logic             Par_err,
   output logic             Stop_err,
   output logic             Busy
);

   localparam int CW = $clog2(Prescale);
   localparam int BW = (Width > 1) ? $clog2(Width) : 1;
   localparam logic [CW-1:0] OS_S0   = CW'(Prescale/2 - 1);
   localparam logic [CW-1:0] OS_S1   = CW'(Prescale/2);
   localparam logic [CW-1:0] OS_S2   = CW'(Prescale/2 + 1);
   localparam logic [CW-1:0] OS_LAST = CW'(Prescale - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(Width - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state, nxt;
   logic             rx_q1, rx_s;
   logic [CW-1:0]    os_cnt;
   logic [BW-1:0]    bit_cnt;
   logic             s0, s1;
   logic [Width-1:0] shift;
   logic             par_bit, pen_l, ptyp_l;
   logic             tick, wrap, bit_val, par_bad, stop_tick;

   assign tick    = (os_cnt == OS_S2);
   assign wrap    = (os_cnt == OS_LAST);
   // third vote is the live sample taken at the tick itself
   assign bit_val = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt       = state;
      Busy      = (state != IDLE);
      par_bad   = pen_l && (par_bit != (^shift ^ ptyp_l));
      stop_tick = (state == STOP) && tick;
      case (state)
         IDLE:    if (!rx_s) nxt = START;
         START:   if (tick && bit_val) nxt = IDLE;
                  else if (wrap)       nxt = DATA;
         DATA:    if (wrap && bit_cnt == BIT_LAST) nxt = pen_l ? PARITY : STOP;
         PARITY:  if (wrap) nxt = STOP;
         // leave at the stop sample so a back-to-back start edge is not missed
         STOP:    if (tick) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_q1      <= 1'b1;
         rx_s       <= 1'b1;
         os_cnt     <= '0;
         bit_cnt    <= '0;
         s0         <= 1'b1;
         s1         <= 1'b1;
         shift      <= '0;
         par_bit    <= 1'b0;
         pen_l      <= 1'b0;
         ptyp_l     <= 1'b0;
         P_data     <= '0;
         Data_valid <= 1'b0;
         Par_err    <= 1'b0;
         Stop_err   <= 1'b0;
      end else begin
         rx_q1      <= Rx_in;
         rx_s       <= rx_q1;
         Data_valid <= 1'b0;
         Par_err    <= 1'b0;
         Stop_err   <= 1'b0;

         if (os_cnt == OS_S0) s0 <= rx_s;
         if (os_cnt == OS_S1) s1 <= rx_s;

         if (state == IDLE) begin
            if (!rx_s) begin
               os_cnt <= CW'(1);
               pen_l  <= PAR_EN;
               ptyp_l <= PAR_TYP;
            end else begin
               os_cnt <= '0;
            end
         end else begin
            os_cnt <= wrap ? '0 : os_cnt + CW'(1);
         end

         if (state == START && wrap) bit_cnt <= '0;
         if (state == DATA) begin
            if (tick) shift[bit_cnt] <= bit_val;
            if (wrap && bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + BW'(1);
         end
         if (state == PARITY && tick) par_bit <= bit_val;

         if (stop_tick) begin
            Stop_err <= !bit_val;
            Par_err  <= par_bad;
            if (bit_val && !par_bad) begin
               P_data     <= shift;
               Data_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-banged frames push expected results to a
// scoreboard; a monitor pops and compares on every output pulse.
module tb_uart_rx;

   localparam int W = 8;
   localparam int P = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         Rx_in = 1'b1;
   logic         PAR_EN = 1'b0;
   logic         PAR_TYP = 1'b0;
   logic [W-1:0] P_data;
   logic         Data_valid, Par_err, Stop_err, Busy;

   uart_rx #(.Width(W), .Prescale(P)) dut (
      .clk(clk), .rst(rst), .Rx_in(Rx_in), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .P_data(P_data), .Data_valid(Data_valid), .Par_err(Par_err),
      .Stop_err(Stop_err), .Busy(Busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   flags;   // {Data_valid, Par_err, Stop_err}
      logic [W-1:0] data;
      int           t0;
      int           pe;
   } exp_t;

   exp_t         sb[$];
   int           total = 0;
   int           passed = 0;
   int           cyc = 0;
   logic [W-1:0] last_good = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input bit ok, input int obs, input int exp);
      total++;
      assert (ok) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_eq(input string tag, input int obs, input int exp);
      chk(tag, obs === exp, obs, exp);
   endtask

   // monitor: every pulse cycle must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst && (Data_valid || Par_err || Stop_err)) begin
         if (sb.size() == 0) begin
            chk_eq("unexpected_pulse", {Data_valid, Par_err, Stop_err}, 0);
         end else begin
            exp_t e;
            int lat, le;
            e = sb.pop_front();
            lat = cyc - e.t0;
            le  = (1 + W + e.pe) * P + P/2 + 4;
            chk_eq("pulse_flags", {Data_valid, Par_err, Stop_err}, e.flags);
            chk_eq("p_data", P_data, e.data);
            chk("latency", (lat >= le - 1) && (lat <= le + 1), lat, le);
         end
      end
   end

   task automatic drive_bit(input logic b, input int glitch);
      for (int j = 0; j < P; j++) begin
         @(negedge clk);
         Rx_in = (j == glitch) ? ~b : b;
      end
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         Rx_in = 1'b1;
      end
   endtask

   task automatic send(input logic [W-1:0] d, input bit pe, input bit pt,
                       input bit par_flip, input bit stop_v, input int gbit);
      exp_t e;
      logic pbit;
      pbit = (^d ^ pt) ^ par_flip;
      if (!stop_v)               e.flags = {1'b0, pe & par_flip, 1'b1};
      else if (pe && par_flip)   e.flags = 3'b010;
      else                       e.flags = 3'b100;
      if (e.flags == 3'b100) last_good = d;
      e.data = last_good;
      e.pe   = pe;
      PAR_EN  = pe;
      PAR_TYP = pt;
      @(negedge clk);
      Rx_in = 1'b0;
      e.t0  = cyc;
      sb.push_back(e);
      for (int j = 1; j < P; j++) @(negedge clk);
      chk_eq("busy_in_frame", Busy, 1);
      for (int i = 0; i < W; i++) drive_bit(d[i], (i == gbit) ? P/2 : -1);
      if (pe) drive_bit(pbit, -1);
      drive_bit(stop_v, -1);
   endtask

   task automatic drain;
      for (int j = 0; j < 40 && sb.size() != 0; j++) @(negedge clk);
      chk_eq("scoreboard_empty", sb.size(), 0);
   endtask

   initial begin
      // reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_eq("rst_p_data", P_data, 0);
      chk_eq("rst_data_valid", Data_valid, 0);
      chk_eq("rst_par_err", Par_err, 0);
      chk_eq("rst_stop_err", Stop_err, 0);
      chk_eq("rst_busy", Busy, 0);
      rst = 1'b1;
      idle(5);

      // plain frame, then parity frames of both types
      send(8'h81, 0, 0, 0, 1, -1); idle(4);
      send(8'h7f, 1, 0, 0, 1, -1); idle(4);
      send(8'h7f, 1, 1, 0, 1, -1); idle(4);
      send(8'h86, 1, 0, 0, 1, -1); idle(4);
      send(8'h86, 1, 1, 0, 1, -1); idle(4);
      drain();

      // wrong parity bit: Par_err, P_data keeps 8'h86
      send(8'h81, 1, 0, 1, 1, -1); idle(4);
      drain();

      // stop bit low, then a good frame
      send(8'h55, 0, 0, 0, 0, -1); idle(16);
      send(8'hA5, 0, 0, 0, 1, -1); idle(4);
      drain();

      // 2-clock start glitch: false start, no pulses
      @(negedge clk); Rx_in = 1'b0;
      @(negedge clk); Rx_in = 1'b0;
      idle(14);
      chk_eq("busy_after_false_start", Busy, 0);
      chk_eq("no_pulse_false_start", sb.size(), 0);

      // 1-clock glitch mid data bit is voted out
      send(8'h3c, 0, 0, 0, 1, 2); idle(4);
      drain();

      // back-to-back frames with no idle gap
      send(8'h86, 0, 0, 0, 1, -1);
      send(8'h81, 0, 0, 0, 1, -1); idle(4);
      drain();

      // reset mid-DATA abandons the frame
      PAR_EN = 1'b0;
      drive_bit(1'b0, -1);
      drive_bit(1'b1, -1);
      drive_bit(1'b0, -1);
      drive_bit(1'b1, -1);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); Rx_in = 1'b1;
      @(negedge clk);
      chk_eq("busy_after_mid_reset", Busy, 0);
      chk_eq("pdata_after_mid_reset", P_data, 0);
      rst = 1'b1;
      last_good = '0;
      idle(5);
      send(8'h7f, 0, 0, 0, 1, -1); idle(4);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
